uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL parameter CLKS_PER_BIT, default 1, clock cycles per serial bit; legal values 1 or even ≥2.
REQ-002 SHALL port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL port reset  input  1  reset, synchronous and active-high.
REQ-004 SHALL port rx_data_in  input  1  serial line, idle high.
REQ-005 SHALL port rx_data_out  output  8  last received data byte.
REQ-006 SHALL port rx_valid  output  1  one-cycle pulse, new frame complete.
REQ-007 SHALL port rx_parity_err  output  1  parity mismatch for the frame flagged by rx_valid.
REQ-008 SHALL port rx_frame_err  output  1  stop bit sampled low for the frame flagged by rx_valid.
REQ-009 SHALL port rx_busy  output  1  high while a frame is in progress (any state other than IDLE/WAIT_IDLE).

Function
REQ-010 SHALL accept frames of: start (0), 8 data bits LSB first, even parity bit (= XOR of data bits), stop (1).
REQ-011 SHALL implement states IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
REQ-012 IDLE: on sampled line 0 -> DATA with bit index 0 if CLKS_PER_BIT=1, else -> START with bit counter cleared.
REQ-013 START (CLKS_PER_BIT>1): wait CLKS_PER_BIT/2 cycles, resample; 0 -> DATA, 1 -> IDLE (glitch rejected, no flags, no rx_valid).
REQ-014 DATA/PARITY/STOP SHALL sample once every CLKS_PER_BIT cycles (every cycle when 1), at bit centre.
REQ-015 DATA SHALL shift sampled bit into position bit index; after index 7 -> PARITY; index is 3 bits and SHALL NOT wrap mid-frame.
REQ-016 PARITY SHALL store sampled bit -> STOP.
REQ-017 On STOP sample SHALL, on the next edge: load rx_data_out with the 8 data bits, pulse rx_valid for exactly one cycle, set rx_parity_err = (parity bit != XOR of data), set rx_frame_err = (stop bit == 0).
REQ-018 rx_data_out SHALL be updated on every completed frame, including errored ones; error flags hold until the next rx_valid.
REQ-019 After STOP: stop=1 -> IDLE; stop=0 -> WAIT_IDLE, which SHALL remain until line sampled 1, then -> IDLE (no start detection on a held-low line).
REQ-020 With CLKS_PER_BIT=1, a start bit driven in cycle k SHALL yield rx_valid high in cycle k+11 (plus synchronizer latency, REQ-025).
REQ-021 Back-to-back frames (stop immediately followed by start) SHALL be received without loss.
REQ-022 Unreachable state encodings SHALL return to IDLE on the next edge.

Reset
REQ-023 reset SHALL, on the next clk edge, force state IDLE, counters 0, rx_data_out 8'h00, rx_valid 0, rx_parity_err 0, rx_frame_err 0, rx_busy 0.
REQ-024 reset asserted mid-frame SHALL abandon the frame with no rx_valid; reception resumes from IDLE at the next start bit after reset deasserts.

Configuration
REQ-025 Macro UART_RX_SYNC_EN defined: rx_data_in SHALL pass through a 2-flop synchronizer (reset to 1) before the state machine, adding exactly 2 cycles latency; undefined: rx_data_in feeds the state machine directly, 0 added latency.

Verification
REQ-026 CLKS_PER_BIT=1, no sync: frame 0xA5, parity 0, stop 1, start at cycle k -> rx_valid pulse at k+11, rx_data_out=0xA5, both error flags 0.
REQ-027 Frame 0x01 with parity bit 0 -> rx_valid, rx_data_out=0x01, rx_parity_err=1, rx_frame_err=0.
REQ-028 Frame 0x3C, stop bit 0, line then held low 5 cycles then high -> rx_frame_err=1, rx_busy 0, no new frame until after line returns high.
REQ-029 CLKS_PER_BIT=4: 1-cycle low glitch on idle line -> no rx_valid, state back to IDLE; then valid 0x5A frame -> rx_data_out=0x5A.
REQ-030 Reset asserted at data bit 4 of frame 0xFF, released, then frame 0x12 -> exactly one rx_valid, rx_data_out=0x12.
REQ-031 UART_RX_SYNC_EN defined, repeat REQ-026 -> rx_valid at k+13; two back-to-back frames 0x11, 0x22 -> two rx_valid pulses 11 cycles apart.

Source files
------------

// File: rtl/uart_rx.sv
// UART receiver: start, 8 data bits LSB first, even parity, stop; sampled at bit centre.
// Optional 2-flop input synchronizer enabled by defining UART_RX_SYNC_EN.
`timescale 1ns/1ps

module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_data_in,
  output logic [7:0] rx_data_out,
  output logic       rx_valid,
  output logic       rx_parity_err,
  output logic       rx_frame_err,
  output logic       rx_busy
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam bit ONE_CPB = (CLKS_PER_BIT == 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_IDLE = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       data_q, data_d;
  logic             parity_q, parity_d;
  logic [7:0]       data_out_d;
  logic             valid_d, perr_d, ferr_d, busy_d;
  logic             line;
  logic             sample_tick_c, half_tick_c;

`ifdef UART_RX_SYNC_EN
  logic [1:0] sync_q;

  // Two-stage synchronizer; resets to the idle line level
  always_ff @(posedge clk) begin
    if (reset) sync_q <= 2'b11;
    else       sync_q <= {sync_q[0], rx_data_in};
  end

  assign line = sync_q[1];
`else
  assign line = rx_data_in;
`endif

  assign sample_tick_c = ONE_CPB || (cnt_q == CNT_LAST);
  assign half_tick_c   = (cnt_q == CNT_HALF);

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (!line) state_d = ONE_CPB ? DATA : START;
      START:     if (half_tick_c) state_d = line ? IDLE : DATA;
      DATA:      if (sample_tick_c && (bit_idx_q == 3'd7)) state_d = PARITY;
      PARITY:    if (sample_tick_c) state_d = STOP;
      STOP:      if (sample_tick_c) state_d = line ? IDLE : WAIT_IDLE;
      WAIT_IDLE: if (line) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Datapath and registered-output next values
  always_comb begin
    cnt_d      = cnt_q;
    bit_idx_d  = bit_idx_q;
    data_d     = data_q;
    parity_d   = parity_q;
    data_out_d = rx_data_out;
    valid_d    = 1'b0;
    perr_d     = rx_parity_err;
    ferr_d     = rx_frame_err;
    busy_d     = (state_d == START) || (state_d == DATA) ||
                 (state_d == PARITY) || (state_d == STOP);
    case (state_q)
      IDLE: begin
        cnt_d     = '0;
        bit_idx_d = 3'd0;
      end
      START: begin
        cnt_d = half_tick_c ? '0 : cnt_q + CNT_W'(1);
      end
      DATA: begin
        if (sample_tick_c) begin
          cnt_d             = '0;
          data_d[bit_idx_q] = line;
          // Index saturates at 7; cleared again in IDLE
          if (bit_idx_q != 3'd7) bit_idx_d = bit_idx_q + 3'd1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      PARITY: begin
        if (sample_tick_c) begin
          cnt_d    = '0;
          parity_d = line;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      STOP: begin
        if (sample_tick_c) begin
          cnt_d      = '0;
          data_out_d = data_q;
          valid_d    = 1'b1;
          perr_d     = (parity_q != (^data_q));
          ferr_d     = !line;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        cnt_d     = '0;
        bit_idx_d = 3'd0;
      end
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q         <= '0;
      bit_idx_q     <= 3'd0;
      data_q        <= 8'h00;
      parity_q      <= 1'b0;
      rx_data_out   <= 8'h00;
      rx_valid      <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_busy       <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      bit_idx_q     <= bit_idx_d;
      data_q        <= data_d;
      parity_q      <= parity_d;
      rx_data_out   <= data_out_d;
      rx_valid      <= valid_d;
      rx_parity_err <= perr_d;
      rx_frame_err  <= ferr_d;
      rx_busy       <= busy_d;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Randomized self-checking bench for uart_rx: one instance at 1 clock/bit, one at 4 clocks/bit.
`timescale 1ns/1ps

module tb_uart_rx;

`ifdef UART_RX_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       line1 = 1'b1;
  logic       line4 = 1'b1;
  logic [7:0] d1, d4;
  logic       v1, v4, pe1, pe4, fe1, fe4, b1, b4;

  uart_rx #(.CLKS_PER_BIT(1)) dut1 (
    .clk(clk), .reset(reset), .rx_data_in(line1), .rx_data_out(d1),
    .rx_valid(v1), .rx_parity_err(pe1), .rx_frame_err(fe1), .rx_busy(b1)
  );

  uart_rx #(.CLKS_PER_BIT(4)) dut4 (
    .clk(clk), .reset(reset), .rx_data_in(line4), .rx_data_out(d4),
    .rx_valid(v4), .rx_parity_err(pe4), .rx_frame_err(fe4), .rx_busy(b4)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } frame_t;

  frame_t q1[$];
  frame_t q4[$];
  frame_t exp_q[$];

  // Record every cycle in which rx_valid is seen high
  always @(negedge clk) begin
    if (v1) q1.push_back('{cyc, d1, pe1, fe1});
    if (v4) q4.push_back('{cyc, d4, pe4, fe4});
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_line(input int which, input logic v);
    if (which == 1) line1 = v;
    else            line4 = v;
  endtask

  // Cycle in which rx_valid must appear for a start bit first driven in cycle s
  function automatic int valid_cycle(input int which, input int s);
    int cpb;
    cpb = (which == 1) ? 1 : 4;
    if (cpb == 1) return s + 11 + SYNC_LAT;
    return s + 1 + cpb / 2 + 10 * cpb + SYNC_LAT;
  endfunction

  task automatic send(input int which, input logic [7:0] d, input logic par,
                      input logic stp, input int hold, output int start_cyc);
    int         cpb;
    logic [10:0] bits;
    cpb = (which == 1) ? 1 : 4;
    bits = {stp, par, d, 1'b0};
    start_cyc = cyc;
    for (int i = 0; i < 11; i++) begin
      set_line(which, bits[i]);
      step(cpb);
    end
    if (hold > 0) step(hold);
    set_line(which, 1'b1);
  endtask

  task automatic expect_frame(input int which, input logic [7:0] d, input logic pe,
                              input logic fe, input int exp_cyc);
    frame_t f;
    int     n;
    n = (which == 1) ? q1.size() : q4.size();
    check("frame_avail", 32'(n > 0), 32'd1);
    if (n == 0) return;
    f = (which == 1) ? q1.pop_front() : q4.pop_front();
    check("rx_data_out", 32'(f.d), 32'(d));
    check("rx_parity_err", 32'(f.pe), 32'(pe));
    check("rx_frame_err", 32'(f.fe), 32'(fe));
    if (exp_cyc >= 0) check("valid_cycle", 32'(f.cyc), 32'(exp_cyc));
  endtask

  task automatic check_empty(input int which, input string tag);
    check(tag, 32'((which == 1) ? q1.size() : q4.size()), 32'd0);
  endtask

  initial begin
    int         s, sa, sb, gap;
    logic [7:0] rd;
    logic       inj, stp;
    frame_t     e;

    repeat (3) @(posedge clk);
    #1;
    check("rst_data1", 32'(d1), 32'h00);
    check("rst_valid1", 32'(v1), 32'd0);
    check("rst_perr1", 32'(pe1), 32'd0);
    check("rst_ferr1", 32'(fe1), 32'd0);
    check("rst_busy1", 32'(b1), 32'd0);
    check("rst_data4", 32'(d4), 32'h00);
    check("rst_busy4", 32'(b4), 32'd0);
    reset = 1'b0;
    step(2);

    // Clean frame with exact latency
    send(1, 8'hA5, 1'b0, 1'b1, 0, s);
    step(4);
    expect_frame(1, 8'hA5, 1'b0, 1'b0, valid_cycle(1, s));
    check_empty(1, "a5_single_pulse");

    // Parity error; flag holds afterwards
    send(1, 8'h01, 1'b0, 1'b1, 0, s);
    step(4);
    expect_frame(1, 8'h01, 1'b1, 1'b0, valid_cycle(1, s));
    step(5);
    check("perr_hold", 32'(pe1), 32'd1);
    check_empty(1, "p01_single_pulse");

    // Framing error with line held low, then released
    send(1, 8'h3C, 1'b0, 1'b0, 5, s);
    check("busy_wait_idle", 32'(b1), 32'd0);
    step(15);
    expect_frame(1, 8'h3C, 1'b0, 1'b1, valid_cycle(1, s));
    check("ferr_hold", 32'(fe1), 32'd1);
    check_empty(1, "no_frame_on_low_line");
    send(1, 8'h96, 1'b0, 1'b1, 0, s);
    step(4);
    expect_frame(1, 8'h96, 1'b0, 1'b0, valid_cycle(1, s));

    // Back-to-back frames
    send(1, 8'h11, 1'b0, 1'b1, 0, sa);
    send(1, 8'h22, 1'b0, 1'b1, 0, sb);
    step(4);
    expect_frame(1, 8'h11, 1'b0, 1'b0, valid_cycle(1, sa));
    expect_frame(1, 8'h22, 1'b0, 1'b0, valid_cycle(1, sb));
    check_empty(1, "b2b_two_pulses");

    // Start-bit glitch at 4 clocks/bit, then a real frame
    set_line(4, 1'b0);
    step(1);
    set_line(4, 1'b1);
    step(12);
    check_empty(4, "glitch_no_valid");
    check("glitch_busy", 32'(b4), 32'd0);
    send(4, 8'h5A, 1'b0, 1'b1, 0, s);
    step(8);
    expect_frame(4, 8'h5A, 1'b0, 1'b0, valid_cycle(4, s));
    check_empty(4, "5a_single_pulse");

    // Reset during data bit 4 of 0xFF, held until the frame has passed
    set_line(1, 1'b0);
    step(1);
    for (int i = 0; i < 4; i++) begin
      set_line(1, 1'b1);
      step(1);
    end
    check("busy_mid_frame", 32'(b1), 32'd1);
    reset = 1'b1;
    step(4);
    set_line(1, 1'b0);
    step(1);
    set_line(1, 1'b1);
    step(1);
    check("rst_mid_data", 32'(d1), 32'h00);
    check("rst_mid_busy", 32'(b1), 32'd0);
    reset = 1'b0;
    step(3);
    check_empty(1, "abandoned_no_valid");
    send(1, 8'h12, 1'b0, 1'b1, 0, s);
    step(4);
    expect_frame(1, 8'h12, 1'b0, 1'b0, valid_cycle(1, s));
    check_empty(1, "after_reset_one_pulse");

    // Random frames on both instances
    for (int w = 0; w < 2; w++) begin
      int which;
      which = (w == 0) ? 1 : 4;
      exp_q.delete();
      for (int n = 0; n < 12; n++) begin
        rd  = 8'($urandom);
        inj = ($urandom_range(0, 3) == 0);
        stp = ($urandom_range(0, 4) != 0);
        send(which, rd, (^rd) ^ inj, stp, 0, s);
        exp_q.push_back('{valid_cycle(which, s), rd, inj, !stp});
        gap = stp ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 2));
        step(gap);
      end
      step(60);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        expect_frame(which, e.d, e.pe, e.fe, e.cyc);
      end
      check_empty(which, "random_no_extra");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
